lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 28 ++
 rtl/seg_hex.sv | 32 +++
 rtl/lfsr_checker.sv | 133 +++++++++++++
 tb/tb_lfsr_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS-8 stream checker: state encodings, tap mask,
// fill/lock/loss thresholds and the LFSR feedback helper.
package lfsr_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   // Taps 0,2,3,4 of the right-shifting register (newest bit enters at [7]).
   localparam logic [7:0] TAP_MASK = 8'b0001_1101;

   localparam int FILL_LEN    = 8;
   localparam int LOCK_THRESH = 16;
   localparam int LOSS_THRESH = 4;

   localparam int FILL_W  = $clog2(FILL_LEN) + 1;
   localparam int MATCH_W = $clog2(LOCK_THRESH) + 1;
   localparam int MISS_W  = $clog2(LOSS_THRESH) + 1;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic lfsr_fb(input logic [7:0] r);
      return ^(r & TAP_MASK);
   endfunction

endpackage

// File: rtl/seg_hex.sv
// Hex nibble to active-low seven-segment pattern {dp,g,f,e,d,c,b,a}; dp kept off.
module seg_hex
   import lfsr_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (hex_i)
         4'h0:    seg_o = 8'hC0;
         4'h1:    seg_o = 8'hF9;
         4'h2:    seg_o = 8'hA4;
         4'h3:    seg_o = 8'hB0;
         4'h4:    seg_o = 8'h99;
         4'h5:    seg_o = 8'h92;
         4'h6:    seg_o = 8'h82;
         4'h7:    seg_o = 8'hF8;
         4'h8:    seg_o = 8'h80;
         4'h9:    seg_o = 8'h90;
         4'hA:    seg_o = 8'h88;
         4'hB:    seg_o = 8'h83;
         4'hC:    seg_o = 8'hC6;
         4'hD:    seg_o = 8'hA1;
         4'hE:    seg_o = 8'h86;
         4'hF:    seg_o = 8'h8E;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS-8 receive checker: hunt / verify / locked (flywheel) with saturating error count.
// Define LFSR_CHK_SEG_EN to drive err_cnt[7:0] onto seg1/seg0; otherwise both are blanked.
module lfsr_checker
   import lfsr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_in,
   input  logic        bit_valid,
   input  logic        err_clr,
   output logic        locked,
   output logic [1:0]  state,
   output logic        zero_flag,
   output logic [15:0] err_cnt,
   output logic [7:0]  seg0,
   output logic [7:0]  seg1
);

   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(FILL_LEN - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
   localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);

   state_e              state_q, state_d;
   logic [7:0]          r_q, r_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [MATCH_W-1:0]  match_q, match_d;
   logic [MISS_W-1:0]   miss_q, miss_d;
   logic [15:0]         err_q, err_d;

   logic                exp_bit;
   logic [7:0]          shift_rx;
   logic [7:0]          shift_fw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_HUNT;
         r_q     <= 8'h00;
         fill_q  <= '0;
         match_q <= '0;
         miss_q  <= '0;
         err_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         miss_q  <= miss_d;
         err_q   <= err_d;
      end
   end

   assign exp_bit  = lfsr_fb(r_q);
   assign shift_rx = {bit_in, r_q[7:1]};
   assign shift_fw = {exp_bit, r_q[7:1]};

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      fill_d  = fill_q;
      match_d = match_q;
      miss_d  = miss_q;
      err_d   = err_q;

      if (bit_valid) begin
         case (state_q)
            ST_VERIFY: begin
               r_d = shift_rx;
               // An all-zero register would self-match a zero stream forever; treat it as a miss.
               if ((r_q == 8'h00) || (bit_in != exp_bit)) begin
                  state_d = ST_HUNT;
                  fill_d  = FILL_W'(1);
                  match_d = '0;
               end else if (match_q == MATCH_LAST) begin
                  state_d = ST_LOCKED;
                  match_d = '0;
                  miss_d  = '0;
               end else begin
                  match_d = match_q + 1'b1;
               end
            end
            ST_LOCKED: begin
               r_d = shift_fw;
               if (bit_in != exp_bit) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  if (miss_q == MISS_LAST) begin
                     state_d = ST_HUNT;
                     fill_d  = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: begin
               state_d = ST_HUNT;
               r_d     = shift_rx;
               if (fill_q == FILL_LAST) begin
                  state_d = ST_VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
         endcase
      end

      if (err_clr) err_d = 16'h0000;
   end

   assign locked    = (state_q == ST_LOCKED);
   assign state     = state_q;
   assign zero_flag = (r_q == 8'h00);
   assign err_cnt   = err_q;

`ifdef LFSR_CHK_SEG_EN
   seg_hex u_seg0 (
      .hex_i (err_q[3:0]),
      .seg_o (seg0)
   );

   seg_hex u_seg1 (
      .hex_i (err_q[7:4]),
      .seg_o (seg1)
   );
`else
   assign seg0 = SEG_BLANK;
   assign seg1 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized bench for lfsr_checker against a bit-history reference model plus directed scenarios.
module tb_lfsr_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        bit_in;
   logic        bit_valid;
   logic        err_clr;
   logic        locked;
   logic [1:0]  state;
   logic        zero_flag;
   logic [15:0] err_cnt;
   logic [7:0]  seg0;
   logic [7:0]  seg1;

   always #5 clk = ~clk;

   lfsr_checker dut (
      .clk       (clk),
      .rst       (rst),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .err_clr   (err_clr),
      .locked    (locked),
      .state     (state),
      .zero_flag (zero_flag),
      .err_cnt   (err_cnt),
      .seg0      (seg0),
      .seg1      (seg1)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: history of the bits the receiver holds, newest at the back.
   int hist[$];
   int m_mode;
   int m_fill;
   int m_run;
   int m_miss;
   int m_errs;
   int gen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_exp();
      int n = hist.size();
      return hist[n-8] ^ hist[n-6] ^ hist[n-5] ^ hist[n-4];
   endfunction

   function automatic int m_window_zero();
      int n = hist.size();
      for (int i = n - 8; i < n; i++)
         if (hist[i] != 0) return 0;
      return 1;
   endfunction

   function automatic logic [7:0] seg_ref(input int v);
      logic [7:0] tbl [16];
      tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`ifdef LFSR_CHK_SEG_EN
      return tbl[v % 16];
`else
      return (tbl[v % 16] == 8'h00) ? 8'h00 : 8'hFF;
`endif
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (8) hist.push_back(0);
      m_mode = 0; m_fill = 0; m_run = 0; m_miss = 0; m_errs = 0;
   endtask

   task automatic model_push(input int b);
      hist.push_back(b);
      if (hist.size() > 16) void'(hist.pop_front());
   endtask

   task automatic model_step(input int b, input bit v, input bit clr);
      int e;
      if (v) begin
         if (m_mode == 0) begin
            model_push(b);
            m_fill++;
            if (m_fill == 8) begin m_mode = 1; m_fill = 0; m_run = 0; end
         end else if (m_mode == 1) begin
            if (m_window_zero() == 1 || b != m_exp()) begin
               model_push(b); m_mode = 0; m_fill = 1; m_run = 0;
            end else begin
               model_push(b); m_run++;
               if (m_run == 16) begin m_mode = 2; m_miss = 0; m_run = 0; end
            end
         end else begin
            e = m_exp();
            model_push(e);
            if (b != e) begin
               if (m_errs < 65535) m_errs++;
               m_miss++;
               if (m_miss == 4) begin m_mode = 0; m_fill = 0; m_miss = 0; end
            end else begin
               m_miss = 0;
            end
         end
      end
      if (clr) m_errs = 0;
   endtask

   task automatic compare_all();
      check("state", state, m_mode);
      check("locked", locked, (m_mode == 2) ? 1 : 0);
      check("zero_flag", zero_flag, m_window_zero());
      check("err_cnt", err_cnt, m_errs);
      check("seg0", seg0, seg_ref(m_errs % 16));
      check("seg1", seg1, seg_ref((m_errs / 16) % 16));
   endtask

   // Reference PRBS transmitter: emits the feedback bit and shifts it in at the top.
   task automatic gen_next(output int b);
      b = ((gen >> 0) ^ (gen >> 2) ^ (gen >> 3) ^ (gen >> 4)) & 1;
      gen = (gen >> 1) | (b << 7);
   endtask

   task automatic cycle(input int b, input bit v, input bit clr);
      @(negedge clk);
      bit_in = b[0]; bit_valid = v; err_clr = clr;
      @(posedge clk);
      model_step(b & 1, v, clr);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0; bit_valid = 1'b0; err_clr = 1'b0; bit_in = 1'b0;
      #1;
      model_reset();
      check("rst_locked", locked, 0);
      check("rst_err", err_cnt, 0);
      compare_all();
      @(negedge clk);
      rst = 1'b1;
      gen = 8'h01;
   endtask

   task automatic run_until_lock(input int valid_pct, output int nvalid);
      int b;
      bit v;
      nvalid = 0;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 99) < valid_pct);
         if (v) gen_next(b); else b = $urandom_range(0, 1);
         cycle(b, v, 1'b0);
         if (v) nvalid++;
         if (locked === 1'b1) return;
      end
      nvalid = -1;
   endtask

   task automatic clean_bits(input int n);
      int b;
      for (int i = 0; i < n; i++) begin gen_next(b); cycle(b, 1'b1, 1'b0); end
   endtask

   initial begin
      int nv;
      int b;
      int burst;
      bit v;
      bit flip;
      bit clr;
      rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; err_clr = 1'b0; gen = 8'h01;
      model_reset();
      #1;
      check("reset_seg0", seg0, seg_ref(0));
      do_reset();

      // Clean stream from seed 1, valid every cycle.
      run_until_lock(100, nv);
      check("lock_bits_full", nv, 24);
      check("lock_err", err_cnt, 0);

      // Single line error while locked.
      clean_bits(20);
      gen_next(b); cycle(b ^ 1, 1'b1, 1'b0);
      clean_bits(30);
      check("single_err", err_cnt, 1);
      check("single_locked", locked, 1);

      // Bursts of 3 keep lock and build err_cnt to 0x12.
      gen_next(b); cycle(b, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 3; j++) begin gen_next(b); cycle(b ^ 1, 1'b1, 1'b0); end
         clean_bits(2);
      end
      check("err_0x12", err_cnt, 16'h0012);
      check("seg0_2", seg0, seg_ref(2));
      check("seg1_1", seg1, seg_ref(1));
      gen_next(b); cycle(b ^ 1, 1'b1, 1'b1);
      check("clr_wins", err_cnt, 0);
      check("clr_seg0", seg0, seg_ref(0));
      check("clr_seg1", seg1, seg_ref(0));
      clean_bits(1);

      // Four consecutive inverted bits drop lock.
      for (int j = 0; j < 4; j++) begin gen_next(b); cycle(b ^ 1, 1'b1, 1'b0); end
      check("loss_err", err_cnt, 4);
      check("loss_state", state, 0);
      check("loss_locked", locked, 0);

      // Half-rate valid: lock still needs exactly 24 accepted bits.
      do_reset();
      run_until_lock(50, nv);
      check("lock_bits_half", nv, 24);
      check("half_err", err_cnt, 0);

      // Asynchronous reset while locked with pending errors.
      gen_next(b); cycle(b ^ 1, 1'b1, 1'b0);
      clean_bits(1);
      gen_next(b); cycle(b ^ 1, 1'b1, 1'b0);
      check("pre_rst_err", err_cnt, 2);
      do_reset();

      // Constant zero input never gets past VERIFY.
      for (int i = 0; i < 100; i++) begin
         cycle(0, 1'b1, 1'b0);
         check("zero_le_verify", (state <= 2'd1) ? 1 : 0, 1);
         check("zero_zflag", zero_flag, 1);
      end
      check("zero_locked", locked, 0);

      // Randomized soak with error bursts, gaps and clears.
      do_reset();
      burst = 0;
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 99) < 80);
         flip = 1'b0;
         if (v) begin
            gen_next(b);
            if (burst > 0) begin flip = 1'b1; burst--; end
            else if ($urandom_range(0, 99) < 3) begin flip = 1'b1; burst = $urandom_range(0, 4); end
         end else begin
            b = $urandom_range(0, 1);
         end
         clr = ($urandom_range(0, 199) == 0);
         cycle(b ^ int'(flip), v, clr);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
